alu_execute_stage: RTL
======================

Name: alu_execute_stage

Overview:
- Pipeline stage that wraps the combinational ALU.
- On the input side it accepts decoded instructions with a valid/ready handshake, resolves operands with two-level forwarding and presents registered operands and function code to the ALU.
- On the output side it retires the ALU result into a registered writeback port, a compare flag, a sticky overflow flag and a retire counter.
- Sits between decode/register-read and the register-file write port.

Parameters:
- DATA_WIDTH, 16, operand/result width (matches definitions package).
- FUNC_WIDTH, 4, ALU function code width (matches definitions package).
- REG_ADDR_WIDTH, 3, register index width; register 0 reads as zero.
- IMM_WIDTH, 8, immediate width, sign-extended to DATA_WIDTH.
- COUNT_WIDTH, 16, retire counter width.

Ports:
- _clock  in  1  rising-edge clock
- _reset  in  1  synchronous, active-high reset
- _inValid  in  1  decoded instruction valid
- inReady  out  1  stage can accept an instruction this cycle
- _srcA, _srcB  in  REG_ADDR_WIDTH  source register indices
- _regA, _regB  in  DATA_WIDTH  register-file read data for _srcA/_srcB (same cycle)
- _immediate  in  IMM_WIDTH  immediate operand
- _useImm  in  1  operand B = sign-extended immediate
- _funcCode  in  FUNC_WIDTH  ALU function
- _dest  in  REG_ADDR_WIDTH  destination register
- _writeEn  in  1  instruction writes _dest
- _stall  in  1  hold execute stage
- _clearOverflow  in  1  clear sticky overflow
- valA, valB  out  DATA_WIDTH  registered ALU operands
- funcCode  out  FUNC_WIDTH  registered ALU function
- exValid  out  1  execute register holds an instruction
- _aluResult  in  DATA_WIDTH  ALU result for current valA/valB/funcCode
- _aluOverflow, _aluCompare  in  1  ALU overflow / compare bit
- wbValid  out  1  writeback valid (one-cycle pulse per writing retire)
- wbDest  out  REG_ADDR_WIDTH  writeback register
- wbData  out  DATA_WIDTH  writeback data
- compareFlag  out  1  last compare result
- overflowSticky  out  1  sticky overflow
- retiredCount  out  COUNT_WIDTH  retired instruction count

Behaviour:
- Reset (synchronous, _reset high at edge): all outputs 0, internal exDest/exWriteEn 0. Reset overrides every other event, including mid-stall and mid-handshake.
- retire = exValid & !_stall. inReady = !exValid | !_stall (combinational).
- accept = _inValid & inReady.
  - On accept: valA, valB, funcCode load; exValid <= 1.
  - On retire without accept: exValid <= 0.
  - When _stall=1 and exValid=1, the execute register holds unchanged.
- Operand A resolution at the accept edge, first match wins:
  1. _srcA==0 → 0.
  2. exValid & exWriteEn & exDest==_srcA → _aluResult. Safe because accept with exValid implies retire on the same edge.
  3. wbValid & wbDest==_srcA → wbData.
  4. Otherwise _regA.
- Operand B: if _useImm, the sign-extended immediate; else the same rules as A using _srcB/_regB.
- Writeback: at the retire edge, wbValid <= exWriteEn, wbDest <= exDest, wbData <= _aluResult. In any cycle without retire, wbValid <= 0; wbDest/wbData hold. The register file writes on the edge where wbValid=1, so its read data is stale for exactly one cycle, which forwarding rule 3 covers.
- Compare ops: on retire with funcCode in {FUNC_LSS, FUNC_EQL, FUNC_GRT}, compareFlag <= _aluCompare. Otherwise compareFlag holds.
- Overflow: on retire with _aluOverflow=1, overflowSticky <= 1. Else if _clearOverflow, overflowSticky <= 0. Set wins over a simultaneous clear.
- retiredCount increments by 1 on every retire and wraps from all-ones to 0.
- Latency: accept edge → ALU operands valid the next cycle → retire edge (earliest the same cycle) → wbValid the following cycle. Throughput is one instruction per cycle with no stall.
- _stall with exValid=0: stage is empty, so inReady=1 and one instruction may be accepted; it then holds until _stall drops.

Test Plan:
- Reset: assert _reset for 2 cycles with _inValid=1 → all outputs 0, inReady=1; the first accept occurs only after _reset drops.
- Back-to-back RAW hazard: ADD r1=r2(5)+imm 3, then ADD r3=r1+r1 the next cycle → second valA=valB=8 via ALU forward; wbData=8 then 16 on consecutive wbValid pulses.
- Writeback forward: producer r1=7, one bubble, consumer reads r1 while _regA still shows 0 → valA=7 via wb forward. A further-delayed consumer uses _regA.
- Stall: exValid=1, _stall=1 for 3 cycles → inReady=0, valA/funcCode hold, wbValid=0, retiredCount unchanged. Release → one retire, count +1.
- Flags: LSS with -2 vs 1 → compareFlag=1. ADD 0x7FFF+1 with _aluOverflow=1 and _clearOverflow=1 the same cycle → overflowSticky=1; a later clear alone → 0.
- Register 0 and counter wrap: _srcA=0 while ex dest 0 writes 9 → valA=0. Preload retiredCount to 0xFFFF (via 65535 retires or force) → the next retire gives 0.

Source files
------------

// File: rtl/alu_execute_stage.sv
// alu_execute_stage: execute pipeline stage with operand forwarding around an external combinational ALU
module alu_execute_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int FUNC_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int IMM_WIDTH      = 8,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic                      _inValid,
    output logic                      inReady,
    input  logic [REG_ADDR_WIDTH-1:0] _srcA,
    input  logic [REG_ADDR_WIDTH-1:0] _srcB,
    input  logic [DATA_WIDTH-1:0]     _regA,
    input  logic [DATA_WIDTH-1:0]     _regB,
    input  logic [IMM_WIDTH-1:0]      _immediate,
    input  logic                      _useImm,
    input  logic [FUNC_WIDTH-1:0]     _funcCode,
    input  logic [REG_ADDR_WIDTH-1:0] _dest,
    input  logic                      _writeEn,
    input  logic                      _stall,
    input  logic                      _clearOverflow,
    output logic [DATA_WIDTH-1:0]     valA,
    output logic [DATA_WIDTH-1:0]     valB,
    output logic [FUNC_WIDTH-1:0]     funcCode,
    output logic                      exValid,
    input  logic [DATA_WIDTH-1:0]     _aluResult,
    input  logic                      _aluOverflow,
    input  logic                      _aluCompare,
    output logic                      wbValid,
    output logic [REG_ADDR_WIDTH-1:0] wbDest,
    output logic [DATA_WIDTH-1:0]     wbData,
    output logic                      compareFlag,
    output logic                      overflowSticky,
    output logic [COUNT_WIDTH-1:0]    retiredCount
);
    localparam logic [FUNC_WIDTH-1:0] FUNC_LSS = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] FUNC_EQL = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] FUNC_GRT = FUNC_WIDTH'(10);

    logic                      retire, accept, isCompare, exWriteEn;
    logic [REG_ADDR_WIDTH-1:0] exDest;
    logic [DATA_WIDTH-1:0]     immExt, nextA, nextB;

    // Handshake and operand resolution; the newest in-flight producer wins over the one in writeback
    always_comb begin
        retire    = exValid & ~_stall;
        inReady   = ~exValid | ~_stall;
        accept    = _inValid & inReady;
        isCompare = funcCode inside {FUNC_LSS, FUNC_EQL, FUNC_GRT};
        immExt    = {{(DATA_WIDTH-IMM_WIDTH){_immediate[IMM_WIDTH-1]}}, _immediate};
        nextA     = (_srcA == '0) ? '0 :
                    (exValid && exWriteEn && exDest == _srcA) ? _aluResult :
                    (wbValid && wbDest == _srcA) ? wbData : _regA;
        nextB     = _useImm ? immExt :
                    (_srcB == '0) ? '0 :
                    (exValid && exWriteEn && exDest == _srcB) ? _aluResult :
                    (wbValid && wbDest == _srcB) ? wbData : _regB;
    end

    // Execute register: loads on accept, empties on a retire with nothing behind it, holds under stall
    always_ff @(posedge _clock) begin
        if (_reset) begin
            valA      <= '0;
            valB      <= '0;
            funcCode  <= '0;
            exDest    <= '0;
            exWriteEn <= 1'b0;
            exValid   <= 1'b0;
        end else if (accept) begin
            valA      <= nextA;
            valB      <= nextB;
            funcCode  <= _funcCode;
            exDest    <= _dest;
            exWriteEn <= _writeEn;
            exValid   <= 1'b1;
        end else if (retire) begin
            exValid   <= 1'b0;
        end
    end

    // Writeback port: one-cycle valid pulse per writing retire, address/data hold otherwise
    always_ff @(posedge _clock) begin
        if (_reset) begin
            wbValid <= 1'b0;
            wbDest  <= '0;
            wbData  <= '0;
        end else begin
            wbValid <= retire & exWriteEn;
            if (retire) begin
                wbDest <= exDest;
                wbData <= _aluResult;
            end
        end
    end

    // Status: compare flag, sticky overflow (set beats clear) and wrapping retire counter
    always_ff @(posedge _clock) begin
        if (_reset) begin
            compareFlag    <= 1'b0;
            overflowSticky <= 1'b0;
            retiredCount   <= '0;
        end else begin
            if (retire && isCompare) compareFlag <= _aluCompare;
            if (retire && _aluOverflow) overflowSticky <= 1'b1;
            else if (_clearOverflow) overflowSticky <= 1'b0;
            if (retire) retiredCount <= retiredCount + 1'b1;
        end
    end
endmodule
